// File: rtl/test_i5433.sv
// test_i5433: six-input, three-flop state machine with a registered response Y and a
// sticky run-length trigger that inverts Y once eight consecutive all-ones samples occur.
module test_i5433 (
  input  logic CK,
  input  logic reset,
  input  logic N0,
  input  logic N1,
  input  logic N2,
  input  logic N3,
  input  logic N4,
  input  logic N5,
  output logic Y
);

  logic       sa_r;
  logic       sb_r;
  logic       sc_r;
  logic [2:0] cnt_r;
  logic       trig_r;
  logic       y_r;

  logic       f_s;
  logic       g_s;
  logic       all1_s;
  logic       base_s;
  logic       sa_nxt_s;
  logic       sb_nxt_s;
  logic       sc_nxt_s;
  logic       y_nxt_s;
  logic [2:0] cnt_nxt_s;
  logic       trig_nxt_s;

  // Input terms and next values of the state chain and response
  always_comb begin
    f_s      = (N0 & N1) | (N2 ^ N3);
    g_s      = ~(N4 & N5);
    all1_s   = N0 & N1 & N2 & N3 & N4 & N5;
    base_s   = (sa_r ^ sb_r) | (sc_r & ~N4);
    sa_nxt_s = f_s ^ sc_r;
    sb_nxt_s = g_s & sa_r;
    sc_nxt_s = sb_r | (N0 & N5);
    y_nxt_s  = base_s ^ trig_r;
  end

  // Run counter holds at 7; the eighth consecutive all-ones sample latches the trigger
  always_comb begin
    cnt_nxt_s  = 3'd0;
    trig_nxt_s = trig_r;
    if (all1_s) begin
      if (cnt_r == 3'd7) begin
        cnt_nxt_s  = 3'd7;
        trig_nxt_s = 1'b1;
      end else begin
        cnt_nxt_s  = cnt_r + 3'd1;
        trig_nxt_s = trig_r;
      end
    end else begin
      cnt_nxt_s  = 3'd0;
      trig_nxt_s = trig_r;
    end
  end

  // State, counter, trigger and response flops with synchronous reset
  always_ff @(posedge CK) begin
    if (reset) begin
      sa_r   <= 1'b0;
      sb_r   <= 1'b0;
      sc_r   <= 1'b0;
      cnt_r  <= 3'd0;
      trig_r <= 1'b0;
      y_r    <= 1'b0;
    end else begin
      sa_r   <= sa_nxt_s;
      sb_r   <= sb_nxt_s;
      sc_r   <= sc_nxt_s;
      cnt_r  <= cnt_nxt_s;
      trig_r <= trig_nxt_s;
      y_r    <= y_nxt_s;
    end
  end

  assign Y = y_r;

endmodule

// File: tb/tb_test_i5433.sv
// Self-checking bench for test_i5433: a behavioural model or fixed tables push expected Y
// into a scoreboard queue at each stimulus edge; each test pops and compares after the edge.
module tb_test_i5433;

  logic CK = 1'b0;
  logic reset;
  logic N0, N1, N2, N3, N4, N5;
  logic Y;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  logic       m_sa, m_sb, m_sc, m_trig, m_y;
  logic [2:0] m_cnt;

  test_i5433 dut (
    .CK(CK), .reset(reset),
    .N0(N0), .N1(N1), .N2(N2), .N3(N3), .N4(N4), .N5(N5),
    .Y(Y)
  );

  always #5 CK = ~CK;

  task automatic set_n(input logic [5:0] v);
    {N0, N1, N2, N3, N4, N5} = v;
  endtask

  // Advance the reference model by one rising edge using the inputs now applied.
  task automatic model_edge();
    logic [2:0] st;
    logic       base;
    logic       a1;
    if (reset) begin
      {m_sa, m_sb, m_sc} = 3'b000;
      m_cnt  = 3'd0;
      m_trig = 1'b0;
      m_y    = 1'b0;
    end else begin
      a1   = &{N0, N1, N2, N3, N4, N5};
      base = (m_sa ^ m_sb) | (m_sc & ~N4);
      st[2] = ((N0 & N1) | (N2 ^ N3)) ^ m_sc;
      st[1] = ~(N4 & N5) & m_sa;
      st[0] = m_sb | (N0 & N5);
      m_y  = base ^ m_trig;
      {m_sa, m_sb, m_sc} = st;
      if (!a1) m_cnt = 3'd0;
      else if (m_cnt != 3'd7) m_cnt = m_cnt + 3'd1;
      else m_trig = 1'b1;
    end
  endtask

  // Push the expected Y for the coming edge (table value if use_tab), then step past it.
  task automatic clock_edge(input bit use_tab, input bit tab_val);
    model_edge();
    exp_q.push_back(use_tab ? tab_val : m_y);
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset();
    bit e;
    reset = 1'b1;
    set_n(6'b111111);
    clock_edge(1'b1, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (Y !== e) begin errors++; $display("FAIL reset_y: got %b want %b", Y, e); end
    checks++;
    if (dut.cnt_r !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt_r); end
    checks++;
    if (dut.trig_r !== 1'b0) begin errors++; $display("FAIL reset_trig: got %b want 0", dut.trig_r); end
    reset = 1'b0;
  endtask

  task automatic test_idle_zero();
    bit e;
    reset = 1'b1;
    clock_edge(1'b1, 1'b0);
    void'(exp_q.pop_front());
    reset = 1'b0;
    set_n(6'b000000);
    for (int i = 0; i < 10; i++) begin
      clock_edge(1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (Y !== e) begin errors++; $display("FAIL idle_y edge %0d: got %b want %b", i + 1, Y, e); end
    end
    checks++;
    if (dut.cnt_r !== 3'd0 || dut.trig_r !== 1'b0)
      begin errors++; $display("FAIL idle_state: cnt %0d trig %b want 0 0", dut.cnt_r, dut.trig_r); end
  endtask

  task automatic test_n0n1_pattern();
    bit e;
    bit tab[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    reset = 1'b1;
    clock_edge(1'b1, 1'b0);
    void'(exp_q.pop_front());
    reset = 1'b0;
    set_n(6'b110000);
    for (int i = 0; i < 13; i++) begin
      clock_edge(1'b1, tab[i]);
      e = exp_q.pop_front();
      checks++;
      if (Y !== e) begin errors++; $display("FAIL n0n1_y edge %0d: got %b want %b", i + 1, Y, e); end
    end
  endtask

  task automatic test_all_ones_trigger();
    bit e;
    bit tab[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    reset = 1'b1;
    clock_edge(1'b1, 1'b0);
    void'(exp_q.pop_front());
    reset = 1'b0;
    set_n(6'b111111);
    for (int i = 0; i < 12; i++) begin
      clock_edge(1'b1, tab[i]);
      e = exp_q.pop_front();
      checks++;
      if (Y !== e) begin errors++; $display("FAIL trig_y edge %0d: got %b want %b", i + 1, Y, e); end
    end
  endtask

  // Runs straight after test_all_ones_trigger: trigger set, state chain at sa,sb,sc = 0,0,1.
  // With N4 = 0 the base term is 1 in every state reached here, so the payload reads as 0.
  task automatic test_post_trigger_reset();
    bit e;
    set_n(6'b000000);
    for (int i = 0; i < 5; i++) begin
      clock_edge(1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (Y !== e) begin errors++; $display("FAIL post_trig_y edge %0d: got %b want %b", i + 1, Y, e); end
    end
    checks++;
    if (dut.trig_r !== 1'b1) begin errors++; $display("FAIL trig_sticky: got %b want 1", dut.trig_r); end
    reset = 1'b1;
    clock_edge(1'b1, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (Y !== e) begin errors++; $display("FAIL post_reset_y: got %b want %b", Y, e); end
    checks++;
    if (dut.trig_r !== 1'b0) begin errors++; $display("FAIL trig_cleared: got %b want 0", dut.trig_r); end
    reset = 1'b0;
    set_n(6'b110000);
    for (int i = 0; i < 3; i++) begin
      clock_edge(1'b1, (i == 1) ? 1'b1 : 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (Y !== e) begin errors++; $display("FAIL post_reset_run edge %0d: got %b want %b", i + 1, Y, e); end
    end
  endtask

  // Reset coincides with all-ones; 7 ones, one zero edge, then a fresh run of 9 ones.
  task automatic test_broken_run();
    bit e;
    reset = 1'b1;
    set_n(6'b111111);
    clock_edge(1'b1, 1'b0);
    void'(exp_q.pop_front());
    checks++;
    if (dut.cnt_r !== 3'd0) begin errors++; $display("FAIL reset_wins_cnt: got %0d want 0", dut.cnt_r); end
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      set_n((i == 7) ? 6'b000000 : 6'b111111);
      clock_edge(1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (Y !== e) begin errors++; $display("FAIL broken_run_y edge %0d: got %b want %b", i + 1, Y, e); end
      if (i == 14) begin
        checks++;
        if (dut.trig_r !== 1'b0) begin errors++; $display("FAIL trig_early: got %b want 0", dut.trig_r); end
      end
      if (i == 15) begin
        checks++;
        if (dut.trig_r !== 1'b1) begin errors++; $display("FAIL trig_on_8th: got %b want 1", dut.trig_r); end
      end
    end
  endtask

  // Even vectors live only in the high phase; odd vectors are the ones sampled.
  task automatic test_sweep();
    bit e;
    reset = 1'b1;
    clock_edge(1'b1, 1'b0);
    void'(exp_q.pop_front());
    reset = 1'b0;
    for (int k = 0; k < 32; k++) begin
      set_n(6'(2 * k));
      @(negedge CK);
      set_n(6'(2 * k + 1));
      clock_edge(1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (Y !== e) begin errors++; $display("FAIL sweep_y pair %0d: got %b want %b", k, Y, e); end
    end
    checks++;
    if (dut.trig_r !== 1'b0) begin errors++; $display("FAIL sweep_trig: got %b want 0", dut.trig_r); end
  endtask

  initial begin
    reset = 1'b1;
    set_n(6'b000000);
    @(negedge CK);
    test_reset();
    test_idle_zero();
    test_n0n1_pattern();
    test_all_ones_trigger();
    test_post_trigger_reset();
    test_broken_run();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
